// File: rtl/core_rd_arbiter_pkg.sv
// Shared types and constants for the two-to-one AXI4-Lite read arbiter.
// Includes the round-robin pick helper used by the top-level FSM.
package core_rd_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_ADDR = 2'd1,
        ARB_DATA = 2'd2
    } arb_state_e;

    typedef enum logic [1:0] {
        ARB_GNT_NONE = 2'd0,
        ARB_GNT_S0   = 2'd1,
        ARB_GNT_S1   = 2'd2
    } arb_gnt_e;

    localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
    localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
    localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

    // On a tie the source that was not served last wins.
    function automatic arb_gnt_e rr_pick(input logic v0, input logic v1,
                                         input logic last_s1);
        arb_gnt_e g;
        g = ARB_GNT_NONE;
        if (v0 && v1)
            g = last_s1 ? ARB_GNT_S0 : ARB_GNT_S1;
        else if (v0)
            g = ARB_GNT_S0;
        else if (v1)
            g = ARB_GNT_S1;
        return g;
    endfunction

endpackage

// File: rtl/core_rd_arbiter.sv
// Two-to-one AXI4-Lite read-channel arbiter (fetch S0, loads S1) onto one
// memory read port; one outstanding read, round-robin grant.
module core_rd_arbiter
    import core_rd_arbiter_pkg::*;
#(
    parameter int AXI_AWIDTH = 4,
    parameter int AXI_DWIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,

    input  logic [AXI_AWIDTH-1:0] s0_axi_araddr_i,
    input  logic                  s0_axi_arvalid_i,
    output logic                  s0_axi_arready_o,
    output logic [AXI_DWIDTH-1:0] s0_axi_rdata_o,
    output logic [1:0]            s0_axi_rresp_o,
    output logic                  s0_axi_rvalid_o,
    input  logic                  s0_axi_rready_i,

    input  logic [AXI_AWIDTH-1:0] s1_axi_araddr_i,
    input  logic                  s1_axi_arvalid_i,
    output logic                  s1_axi_arready_o,
    output logic [AXI_DWIDTH-1:0] s1_axi_rdata_o,
    output logic [1:0]            s1_axi_rresp_o,
    output logic                  s1_axi_rvalid_o,
    input  logic                  s1_axi_rready_i,

    output logic [AXI_AWIDTH-1:0] m_axi_araddr_o,
    output logic                  m_axi_arvalid_o,
    input  logic                  m_axi_arready_i,
    input  logic [AXI_DWIDTH-1:0] m_axi_rdata_i,
    input  logic [1:0]            m_axi_rresp_i,
    input  logic                  m_axi_rvalid_i,
    output logic                  m_axi_rready_o
);

    arb_state_e            state_q, state_d;
    arb_gnt_e              grant_q, grant_d;
    logic                  last_s1_q, last_s1_d;
    logic [AXI_AWIDTH-1:0] araddr_q, araddr_d;
    logic                  arvalid_q, arvalid_d;

    arb_gnt_e pick;
    logic     sel0, sel1;

    always_comb pick = rr_pick(s0_axi_arvalid_i, s1_axi_arvalid_i, last_s1_q);

    // R path: combinational, steered only to the granted source while in DATA.
    always_comb begin
        sel0 = (state_q == ARB_DATA) && (grant_q == ARB_GNT_S0);
        sel1 = (state_q == ARB_DATA) && (grant_q == ARB_GNT_S1);

        s0_axi_rvalid_o = sel0 && m_axi_rvalid_i;
        s0_axi_rdata_o  = sel0 ? m_axi_rdata_i : '0;
        s0_axi_rresp_o  = sel0 ? m_axi_rresp_i : AXI_RESP_OKAY;

        s1_axi_rvalid_o = sel1 && m_axi_rvalid_i;
        s1_axi_rdata_o  = sel1 ? m_axi_rdata_i : '0;
        s1_axi_rresp_o  = sel1 ? m_axi_rresp_i : AXI_RESP_OKAY;

        m_axi_rready_o  = (sel0 && s0_axi_rready_i) || (sel1 && s1_axi_rready_i);
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        last_s1_d        = last_s1_q;
        araddr_d         = araddr_q;
        arvalid_d        = arvalid_q;
        s0_axi_arready_o = 1'b0;
        s1_axi_arready_o = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // Gated by reset so ARREADY reads 0 while reset is held.
                if (rst_ni && (pick != ARB_GNT_NONE)) begin
                    s0_axi_arready_o = (pick == ARB_GNT_S0);
                    s1_axi_arready_o = (pick == ARB_GNT_S1);
                    araddr_d  = (pick == ARB_GNT_S0) ? s0_axi_araddr_i : s1_axi_araddr_i;
                    grant_d   = pick;
                    arvalid_d = 1'b1;
                    state_d   = ARB_ADDR;
                end
            end
            ARB_ADDR: begin
                if (m_axi_arready_i) begin
                    arvalid_d = 1'b0;
                    state_d   = ARB_DATA;
                end
            end
            ARB_DATA: begin
                if (m_axi_rvalid_i && m_axi_rready_o) begin
                    last_s1_d = (grant_q == ARB_GNT_S1);
                    grant_d   = ARB_GNT_NONE;
                    state_d   = ARB_IDLE;
                end
            end
            default: begin
                state_d   = ARB_IDLE;
                grant_d   = ARB_GNT_NONE;
                arvalid_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= ARB_IDLE;
            grant_q   <= ARB_GNT_NONE;
            last_s1_q <= 1'b1;
            araddr_q  <= '0;
            arvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            last_s1_q <= last_s1_d;
            araddr_q  <= araddr_d;
            arvalid_q <= arvalid_d;
        end
    end

    assign m_axi_araddr_o  = araddr_q;
    assign m_axi_arvalid_o = arvalid_q;

endmodule

// File: tb/tb_core_rd_arbiter.sv
// Self-checking bench for core_rd_arbiter: directed vector table, reset
// corner case, then random traffic checked against a round-robin model.
module tb_core_rd_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  s0_araddr, s1_araddr, m_araddr;
    logic        s0_arvalid, s1_arvalid, s0_arready, s1_arready;
    logic [31:0] s0_rdata, s1_rdata, m_rdata;
    logic [1:0]  s0_rresp, s1_rresp, m_rresp;
    logic        s0_rvalid, s1_rvalid, s0_rready, s1_rready;
    logic        m_arvalid, m_arready, m_rvalid, m_rready;

    int total = 0;
    int bad   = 0;
    int txn_n = 0;
    bit last_s1;

    always #5 clk = ~clk;

    core_rd_arbiter #(.AXI_AWIDTH(4), .AXI_DWIDTH(32)) dut (
        .clk_i            (clk),
        .rst_ni           (rst_n),
        .s0_axi_araddr_i  (s0_araddr),
        .s0_axi_arvalid_i (s0_arvalid),
        .s0_axi_arready_o (s0_arready),
        .s0_axi_rdata_o   (s0_rdata),
        .s0_axi_rresp_o   (s0_rresp),
        .s0_axi_rvalid_o  (s0_rvalid),
        .s0_axi_rready_i  (s0_rready),
        .s1_axi_araddr_i  (s1_araddr),
        .s1_axi_arvalid_i (s1_arvalid),
        .s1_axi_arready_o (s1_arready),
        .s1_axi_rdata_o   (s1_rdata),
        .s1_axi_rresp_o   (s1_rresp),
        .s1_axi_rvalid_o  (s1_rvalid),
        .s1_axi_rready_i  (s1_rready),
        .m_axi_araddr_o   (m_araddr),
        .m_axi_arvalid_o  (m_arvalid),
        .m_axi_arready_i  (m_arready),
        .m_axi_rdata_i    (m_rdata),
        .m_axi_rresp_i    (m_rresp),
        .m_axi_rvalid_i   (m_rvalid),
        .m_axi_rready_o   (m_rready)
    );

    typedef struct {
        bit          v0, v1;
        logic [3:0]  a0, a1;
        logic [31:0] rdata;
        logic [1:0]  rresp;
        int          ar_wait, r_wait;
        bit          exp_s1;
    } vec_t;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, req, $time);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_s0_arready"}, s0_arready, 0);
        chk({tag, "_s1_arready"}, s1_arready, 0);
        chk({tag, "_m_arvalid"},  m_arvalid,  0);
        chk({tag, "_m_araddr"},   m_araddr,   0);
        chk({tag, "_s0_rvalid"},  s0_rvalid,  0);
        chk({tag, "_s1_rvalid"},  s1_rvalid,  0);
        chk({tag, "_m_rready"},   m_rready,   0);
    endtask

    // One complete read: accept, AR with ar_wait stall cycles, R with r_wait
    // back-pressure cycles. The losing source keeps ARVALID asserted throughout.
    task automatic txn(input vec_t v);
        logic [3:0] exp_addr;
        exp_addr = v.exp_s1 ? v.a1 : v.a0;
        @(negedge clk);
        s0_arvalid = v.v0; s1_arvalid = v.v1;
        s0_araddr  = v.a0; s1_araddr  = v.a1;
        #1;
        chk("accept_winner_arready", v.exp_s1 ? s1_arready : s0_arready, 1);
        chk("accept_loser_arready",  v.exp_s1 ? s0_arready : s1_arready, 0);
        chk("accept_m_arvalid", m_arvalid, 0);
        @(negedge clk);
        if (v.exp_s1) s1_arvalid = 1'b0; else s0_arvalid = 1'b0;
        // Stray slave RVALID during ADDR must not leak to either source.
        m_rvalid = 1'b1; m_rdata = 32'hBADBAD00; s0_rready = 1'b1; s1_rready = 1'b1;
        #1;
        for (int k = 0; k <= v.ar_wait; k++) begin
            chk("addr_m_arvalid", m_arvalid, 1);
            chk("addr_m_araddr",  m_araddr,  exp_addr);
            chk("addr_arready", {s0_arready, s1_arready}, 0);
            chk("addr_rvalid",  {s0_rvalid, s1_rvalid}, 0);
            chk("addr_m_rready", m_rready, 0);
            if (k < v.ar_wait) begin
                @(negedge clk); #1;
            end
        end
        m_arready = 1'b1; m_rvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
        @(negedge clk);
        m_arready = 1'b0;
        m_rvalid = 1'b1; m_rdata = v.rdata; m_rresp = v.rresp;
        #1;
        chk("data_m_arvalid", m_arvalid, 0);
        for (int k = 0; k < v.r_wait; k++) begin
            chk("bp_m_rready", m_rready, 0);
            chk("bp_rvalid_w", v.exp_s1 ? s1_rvalid : s0_rvalid, 1);
            chk("bp_rdata_w",  v.exp_s1 ? s1_rdata  : s0_rdata,  v.rdata);
            chk("bp_rvalid_l", v.exp_s1 ? s0_rvalid : s1_rvalid, 0);
            chk("bp_arready", {s0_arready, s1_arready}, 0);
            @(negedge clk); #1;
        end
        if (v.exp_s1) s1_rready = 1'b1; else s0_rready = 1'b1;
        #1;
        chk("r_m_rready",  m_rready, 1);
        chk("r_rvalid_w",  v.exp_s1 ? s1_rvalid : s0_rvalid, 1);
        chk("r_rdata_w",   v.exp_s1 ? s1_rdata  : s0_rdata,  v.rdata);
        chk("r_rresp_w",   v.exp_s1 ? s1_rresp  : s0_rresp,  v.rresp);
        chk("r_rvalid_l",  v.exp_s1 ? s0_rvalid : s1_rvalid, 0);
        @(negedge clk);
        m_rvalid = 1'b0; s0_rready = 1'b0; s1_rready = 1'b0;
        last_s1 = v.exp_s1;
        #1;
        // Loser, still waiting, must be accepted in the cycle right after R.
        if (v.v0 && v.v1)
            chk("next_loser_arready", v.exp_s1 ? s0_arready : s1_arready, 1);
        s0_arvalid = 1'b0; s1_arvalid = 1'b0;
        txn_n++;
        $display("txn %0d: grant=S%0d addr=%h rdata=%h rresp=%b ar_wait=%0d r_wait=%0d",
                 txn_n, v.exp_s1, exp_addr, v.rdata, v.rresp, v.ar_wait, v.r_wait);
    endtask

    // Reference: tie goes to whoever was not served last, otherwise the lone requester.
    function automatic bit model_pick(input bit v0, input bit v1);
        if (v0 && v1) return !last_s1;
        return v1;
    endfunction

    vec_t vecs[8];

    initial begin
        vec_t rv;
        int   r;
        rst_n = 1'b0;
        s0_arvalid = 0; s1_arvalid = 0; s0_araddr = 0; s1_araddr = 0;
        s0_rready = 0; s1_rready = 0;
        m_arready = 0; m_rvalid = 0; m_rdata = 0; m_rresp = 0;
        last_s1 = 1'b1;

        vecs[0] = '{1, 1, 4'h8, 4'hC, 32'h11111111, 2'b00, 0, 0, 0};
        vecs[1] = '{0, 1, 4'h8, 4'hC, 32'h22222222, 2'b10, 0, 0, 1};
        vecs[2] = '{1, 1, 4'h8, 4'hC, 32'h33333333, 2'b00, 1, 1, 0};
        vecs[3] = '{0, 1, 4'h8, 4'hC, 32'hDEADBEEF, 2'b00, 0, 2, 1};
        vecs[4] = '{1, 0, 4'h4, 4'h0, 32'h00000013, 2'b00, 0, 0, 0};
        vecs[5] = '{1, 1, 4'h5, 4'h6, 32'h55555555, 2'b11, 3, 0, 1};
        vecs[6] = '{1, 0, 4'h5, 4'h6, 32'h66666666, 2'b00, 0, 0, 0};
        vecs[7] = '{0, 1, 4'h0, 4'h3, 32'h77777777, 2'b10, 2, 1, 1};

        repeat (2) @(negedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) txn(vecs[i]);

        // Reset asserted mid-DATA: outputs must clear without waiting for a clock.
        @(negedge clk);
        s1_arvalid = 1'b1; s1_araddr = 4'h9;
        @(negedge clk);
        s1_arvalid = 1'b0; m_arready = 1'b1;
        @(negedge clk);
        m_arready = 1'b0; m_rvalid = 1'b1; m_rdata = 32'hCAFEF00D;
        #1;
        chk("pre_reset_s1_rvalid", s1_rvalid, 1);
        s0_arvalid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1; m_rvalid = 1'b0; s0_arvalid = 1'b0;
        last_s1 = 1'b1;
        txn('{1, 0, 4'h0, 4'h0, 32'hA5A5A5A5, 2'b00, 0, 0, 0});
        txn('{1, 1, 4'h1, 4'h2, 32'h5A5A5A5A, 2'b00, 0, 0, 1});

        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(1, 3);
            rv.v0 = r[0]; rv.v1 = r[1];
            rv.a0 = 4'($urandom); rv.a1 = 4'($urandom);
            rv.rdata = $urandom; rv.rresp = 2'($urandom);
            rv.ar_wait = $urandom_range(0, 3);
            rv.r_wait  = $urandom_range(0, 3);
            rv.exp_s1 = model_pick(rv.v0, rv.v1);
            txn(rv);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
